// File: rtl/sdram_rd_capture.sv
// sdram_rd_capture: snoops SDRAM command pins, captures READ bursts after CAS
// latency and buffers {first, data} words in a first-word-fall-through FIFO
// that drains over a valid/ready stream.
module sdram_rd_capture #(
  parameter int CAS_LAT   = 3,   // 2..3
  parameter int BURST_LEN = 4,   // 1, 2, 4 or 8
  parameter int DATA_W    = 16,
  parameter int FIFO_AW   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_cs_n,
  input  logic                cmd_ras_n,
  input  logic                cmd_cas_n,
  input  logic                cmd_we_n,
  input  logic [DATA_W-1:0]   dq_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_first,
  output logic [FIFO_AW:0]    fifo_count,
  output logic                overflow,
  output logic                busy
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int BW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0]    LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] PTR_ONE   = (FIFO_AW + 1)'(1);

  typedef enum logic {
    S_IDLE,
    S_CAPT
  } state_t;

  // Command decode: only a selected chip counts.
  logic cmd_read, cmd_bst;
  assign cmd_read = !cmd_cs_n &&  cmd_ras_n && !cmd_cas_n &&  cmd_we_n;
  assign cmd_bst  = !cmd_cs_n &&  cmd_ras_n &&  cmd_cas_n && !cmd_we_n;

  // A marker entering at edge k leaves the top stage at edge k+CAS_LAT,
  // exactly when the first data beat (or first dropped beat) is on dq_in.
  logic [CAS_LAT-1:0] start_sr, bst_sr;
  logic               start_exit, bst_exit;
  assign start_exit = start_sr[CAS_LAT-1];
  assign bst_exit   = bst_sr[CAS_LAT-1];

  // Delay lines for READ and BST markers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking (<=) so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      start_sr <= '0;
      bst_sr   <= '0;
    end else begin
      start_sr <= {start_sr[CAS_LAT-2:0], cmd_read};
      bst_sr   <= {bst_sr[CAS_LAT-2:0], cmd_bst};
    end
  end

  state_t          state, state_nxt;
  logic [BW-1:0]   beat, beat_nxt;   // index of the beat captured at the next edge
  logic            wr_en, wr_first;

  // Capture FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
    end
  end

  // Capture FSM next state and FIFO write request; a new start beats both
  // an expiring BST and the tail of an older burst.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    beat_nxt  = beat;
    wr_en     = 1'b0;
    wr_first  = 1'b0;
    if (start_exit) begin
      wr_en    = 1'b1;
      wr_first = 1'b1;
      if (BURST_LEN == 1) begin
        state_nxt = S_IDLE;
        beat_nxt  = '0;
      end else begin
        state_nxt = S_CAPT;
        beat_nxt  = BW'(1);
      end
    end else if (bst_exit) begin
      state_nxt = S_IDLE;
      beat_nxt  = '0;
    end else if (state == S_CAPT) begin
      wr_en = 1'b1;
      if (beat == LAST_BEAT) begin
        state_nxt = S_IDLE;
        beat_nxt  = '0;
      end else begin
        beat_nxt = beat + BW'(1);
      end
    end
  end

  assign busy = (|start_sr) || (|bst_sr) || (state == S_CAPT);

  // FIFO: extra pointer bit distinguishes full from empty.
  logic [DATA_W:0]  mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             full, pop, push;
  logic [DATA_W:0]  head;

  assign fifo_count = wr_ptr - rd_ptr;
  assign full       = (fifo_count == DEPTH_C);
  assign out_valid  = (fifo_count != '0);
  assign pop        = out_valid && out_ready;
  assign push       = wr_en && (!full || pop);

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; pointers define which
    // entries are meaningful, and out_first is masked while empty.
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {wr_first, dq_in};
  end

  // FIFO pointers and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_en && full && !pop) overflow <= 1'b1;
    end
  end

  assign head      = mem[rd_ptr[FIFO_AW-1:0]];
  assign out_data  = head[DATA_W-1:0];
  assign out_first = out_valid && head[DATA_W];

endmodule

// File: tb/tb_sdram_rd_capture.sv
// Directed bench for sdram_rd_capture: per-edge stimulus schedules, a stream
// monitor collecting popped words, and per-edge logs of status outputs.
module tb_sdram_rd_capture;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int N  = 80;

  logic          clk = 1'b0;
  logic          rst, cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n;
  logic [DW-1:0] dq_in;
  logic          out_valid, out_ready, out_first, overflow, busy;
  logic [DW-1:0] out_data;
  logic [AW:0]   fifo_count;

  sdram_rd_capture #(.CAS_LAT(3), .BURST_LEN(4), .DATA_W(DW), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_cs_n(cmd_cs_n), .cmd_ras_n(cmd_ras_n), .cmd_cas_n(cmd_cas_n), .cmd_we_n(cmd_we_n),
    .dq_in(dq_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .fifo_count(fifo_count), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {C_NOP, C_RD, C_BST} cmd_e;

  // Schedules indexed by edge number (inputs seen at that edge).
  cmd_e          cmd_s [N];
  logic [DW-1:0] dq_s  [N];
  logic          rdy_s [N];
  logic          rst_s [N];
  // Logs indexed by edge number (outputs sampled 1ns after that edge).
  logic          v_log [N];
  logic          b_log [N];
  logic          o_log [N];
  logic          f_log [N];
  logic [AW:0]   c_log [N];

  logic [DW:0] got[$];
  logic [DW:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic clear_sched();
    for (int i = 0; i < N; i++) begin
      cmd_s[i] = C_NOP;
      dq_s[i]  = 16'hEE00 | 16'(i);
      rdy_s[i] = 1'b1;
      rst_s[i] = 1'b0;
    end
    rst_s[0] = 1'b1;
    got.delete();
    exp_q.delete();
  endtask

  task automatic run(input int n);
    for (int e = 0; e < n; e++) begin
      rst = rst_s[e];
      cmd_cs_n  = (cmd_s[e] == C_NOP);
      cmd_ras_n = 1'b1;
      cmd_cas_n = (cmd_s[e] != C_RD);
      cmd_we_n  = (cmd_s[e] != C_BST);
      dq_in     = dq_s[e];
      out_ready = rdy_s[e];
      #1;
      if (out_ready && out_valid && !rst) got.push_back({out_first, out_data});
      @(posedge clk);
      #1;
      v_log[e] = out_valid;
      b_log[e] = busy;
      o_log[e] = overflow;
      f_log[e] = out_first;
      c_log[e] = fifo_count;
    end
  endtask

  task automatic test_reset();
    clear_sched();
    cmd_s[0] = C_RD;  // READ on the reset edge must be ignored
    dq_s[3]  = 16'h1234;
    run(8);
    total++; if (v_log[0] !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", v_log[0]); end
    total++; if (f_log[0] !== 1'b0) begin bad++; $display("FAIL reset_first got=%b exp=0", f_log[0]); end
    total++; if (c_log[0] !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", c_log[0]); end
    total++; if (o_log[0] !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", o_log[0]); end
    total++; if (b_log[0] !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", b_log[0]); end
    total++; if (c_log[7] !== 5'd0) begin bad++; $display("FAIL reset_cmd_ignored count got=%0d exp=0", c_log[7]); end
  endtask

  task automatic test_single();
    clear_sched();
    cmd_s[10] = C_RD;
    for (int i = 0; i < 4; i++) dq_s[13+i] = 16'hA000 + 16'(i);
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 0), 16'hA000 + 16'(i)});
    run(25);
    total++; if (v_log[12] !== 1'b0) begin bad++; $display("FAIL single_valid_e12 got=%b exp=0", v_log[12]); end
    total++; if (v_log[13] !== 1'b1) begin bad++; $display("FAIL single_valid_e13 got=%b exp=1", v_log[13]); end
    total++; if (b_log[15] !== 1'b1) begin bad++; $display("FAIL single_busy_e15 got=%b exp=1", b_log[15]); end
    total++; if (b_log[16] !== 1'b0) begin bad++; $display("FAIL single_busy_e16 got=%b exp=0", b_log[16]); end
    total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL single_nwords got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL single_word[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_sched();
    cmd_s[10] = C_RD;
    cmd_s[14] = C_RD;
    for (int i = 0; i < 4; i++) begin
      dq_s[13+i] = 16'hA000 + 16'(i);
      dq_s[17+i] = 16'hB000 + 16'(i);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 0), 16'hA000 + 16'(i)});
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 0), 16'hB000 + 16'(i)});
    run(28);
    for (int e = 13; e <= 20; e++) begin
      total++; if (v_log[e] !== 1'b1) begin bad++; $display("FAIL b2b_gapless_e%0d got=%b exp=1", e, v_log[e]); end
    end
    total++; if (b_log[19] !== 1'b1) begin bad++; $display("FAIL b2b_busy_e19 got=%b exp=1", b_log[19]); end
    total++; if (b_log[20] !== 1'b0) begin bad++; $display("FAIL b2b_busy_e20 got=%b exp=0", b_log[20]); end
    total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL b2b_nwords got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_word[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_interrupt();
    clear_sched();
    cmd_s[10] = C_RD;
    cmd_s[12] = C_RD;
    dq_s[13] = 16'hA000;
    dq_s[14] = 16'hA001;
    for (int i = 0; i < 4; i++) dq_s[15+i] = 16'hB000 + 16'(i);
    exp_q.push_back({1'b1, 16'hA000});
    exp_q.push_back({1'b0, 16'hA001});
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 0), 16'hB000 + 16'(i)});
    run(26);
    total++; if (b_log[18] !== 1'b0) begin bad++; $display("FAIL intr_busy_e18 got=%b exp=0", b_log[18]); end
    total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL intr_nwords got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL intr_word[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_bst();
    clear_sched();
    cmd_s[10] = C_RD;
    cmd_s[12] = C_BST;
    for (int i = 0; i < 4; i++) dq_s[13+i] = 16'hA000 + 16'(i);
    exp_q.push_back({1'b1, 16'hA000});
    exp_q.push_back({1'b0, 16'hA001});
    run(24);
    total++; if (b_log[14] !== 1'b1) begin bad++; $display("FAIL bst_busy_e14 got=%b exp=1", b_log[14]); end
    total++; if (b_log[15] !== 1'b0) begin bad++; $display("FAIL bst_busy_e15 got=%b exp=0", b_log[15]); end
    total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL bst_nwords got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL bst_word[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    clear_sched();
    for (int k = 0; k < 5; k++) cmd_s[10 + 4*k] = C_RD;
    for (int i = 0; i < 20; i++) dq_s[13+i] = 16'h5000 + 16'(i);
    for (int e = 0; e < 40; e++) rdy_s[e] = 1'b0;
    for (int i = 0; i < 16; i++) exp_q.push_back({(i % 4 == 0), 16'h5000 + 16'(i)});
    run(62);
    total++; if (c_log[39] !== 5'd16) begin bad++; $display("FAIL ovf_count_full got=%0d exp=16", c_log[39]); end
    total++; if (o_log[28] !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", o_log[28]); end
    total++; if (o_log[29] !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", o_log[29]); end
    total++; if (c_log[61] !== 5'd0) begin bad++; $display("FAIL ovf_drained got=%0d exp=0", c_log[61]); end
    total++; if (o_log[61] !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", o_log[61]); end
    total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL ovf_nwords got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_word[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_full_pop();
    clear_sched();
    for (int k = 0; k < 5; k++) cmd_s[10 + 4*k] = C_RD;
    for (int i = 0; i < 20; i++) dq_s[13+i] = 16'h6000 + 16'(i);
    for (int e = 0; e <= 28; e++) rdy_s[e] = 1'b0;
    for (int i = 0; i < 20; i++) exp_q.push_back({(i % 4 == 0), 16'h6000 + 16'(i)});
    run(60);
    total++; if (o_log[0] !== 1'b0) begin bad++; $display("FAIL fullpop_reset_clears_ovf got=%b exp=0", o_log[0]); end
    total++; if (c_log[28] !== 5'd16) begin bad++; $display("FAIL fullpop_count_e28 got=%0d exp=16", c_log[28]); end
    total++; if (c_log[32] !== 5'd16) begin bad++; $display("FAIL fullpop_count_e32 got=%0d exp=16", c_log[32]); end
    total++; if (o_log[59] !== 1'b0) begin bad++; $display("FAIL fullpop_no_ovf got=%b exp=0", o_log[59]); end
    total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL fullpop_nwords got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL fullpop_word[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_mid_reset();
    clear_sched();
    cmd_s[10] = C_RD;
    for (int i = 0; i < 4; i++) dq_s[13+i] = 16'hA000 + 16'(i);
    rst_s[14] = 1'b1;
    for (int e = 0; e <= 20; e++) rdy_s[e] = 1'b0;
    cmd_s[20] = C_RD;
    for (int i = 0; i < 4; i++) dq_s[23+i] = 16'hC000 + 16'(i);
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 0), 16'hC000 + 16'(i)});
    run(34);
    total++; if (c_log[13] !== 5'd1) begin bad++; $display("FAIL mrst_count_e13 got=%0d exp=1", c_log[13]); end
    total++; if (c_log[14] !== 5'd0) begin bad++; $display("FAIL mrst_count_e14 got=%0d exp=0", c_log[14]); end
    total++; if (b_log[14] !== 1'b0) begin bad++; $display("FAIL mrst_busy_e14 got=%b exp=0", b_log[14]); end
    total++; if (c_log[20] !== 5'd0) begin bad++; $display("FAIL mrst_count_e20 got=%0d exp=0", c_log[20]); end
    total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL mrst_nwords got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL mrst_word[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
    end
  endtask

  initial begin
    rst = 1'b1; cmd_cs_n = 1'b1; cmd_ras_n = 1'b1; cmd_cas_n = 1'b1; cmd_we_n = 1'b1;
    dq_in = '0; out_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_interrupt();
    test_bst();
    test_overflow();
    test_full_pop();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
